// File: rtl/tile_read_scheduler.sv
// Tile read scheduler: grants tile fetches from two requesters and walks each tile in raster order on the BRAM read port.
// Build option: define SCHED_STRICT_PRIO_EN for fixed priority (requester 0 always wins) instead of round-robin.

module tile_read_scheduler #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 16,
    parameter int TILE_WIDTH  = 16,
    parameter int TILE_HEIGHT = 16,
    parameter int ADDR_W      = 19,
    parameter int RD_LAT      = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq0_valid,
    input  logic [5:0]        iReq0_tx,
    input  logic [4:0]        iReq0_ty,
    output logic              oReq0_ready,
    input  logic              iReq1_valid,
    input  logic [5:0]        iReq1_tx,
    input  logic [4:0]        iReq1_ty,
    output logic              oReq1_ready,
    output logic              oRd_en,
    output logic [ADDR_W-1:0] oRd_addr,
    input  logic [7:0]        iRd_data,
    output logic              oPix_valid,
    output logic [7:0]        oPix_data,
    output logic              oPix_last,
    output logic              oPix_owner,
    output logic              oErr,
    output logic              oBusy,
    output logic [10:0]       oTile_cnt,
    output logic [1:0]        dbg_state
);

    localparam int TILES_X = IMG_WIDTH / TILE_WIDTH;
    localparam int TILES_Y = IMG_HEIGHT / TILE_HEIGHT;
    localparam int CW = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
    localparam int RW = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(TILE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TILE_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [5:0]        tx_q;
    logic [4:0]        ty_q;
    logic              owner_q;
    logic [RD_LAT-1:0] tag_valid, tag_last, tag_owner;
    logic [10:0]       tile_cnt;

    logic        any_valid, grant, grant_sel, sel_oor;
    logic        rd_en, issue_last, pix_last;
    logic [5:0]  sel_tx;
    logic [4:0]  sel_ty;
    logic [31:0] addr_full;
    logic        addr_unused;

    // Handshake: a requester holds valid and indices stable until it sees a one-cycle
    // ready; ready is only ever given in IDLE, and never while reset is asserted.
    assign any_valid = (iReq0_valid | iReq1_valid) & ~iRst;

`ifdef SCHED_STRICT_PRIO_EN
    assign grant_sel = ~iReq0_valid;
`else
    logic rr_ptr;
    assign grant_sel = (iReq0_valid & iReq1_valid) ? rr_ptr : ~iReq0_valid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= ~grant_sel;
        end
    end
`endif

    assign sel_tx  = grant_sel ? iReq1_tx : iReq0_tx;
    assign sel_ty  = grant_sel ? iReq1_ty : iReq0_ty;
    assign sel_oor = (32'(sel_tx) >= 32'(TILES_X)) || (32'(sel_ty) >= 32'(TILES_Y));

    assign rd_en      = (state == ISSUE);
    assign issue_last = (row == ROW_LAST) && (col == COL_LAST);
    assign pix_last   = tag_valid[RD_LAT-1] & tag_last[RD_LAT-1];

    // Full-precision address; the BRAM only sees the low ADDR_W bits.
    assign addr_full = (32'(ty_q) * 32'(TILE_HEIGHT) + 32'(row)) * 32'(IMG_WIDTH)
                     + 32'(tx_q) * 32'(TILE_WIDTH) + 32'(col);
    assign addr_unused = ^addr_full[31:ADDR_W];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        oReq0_ready = 1'b0;
        oReq1_ready = 1'b0;
        oErr        = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    grant       = 1'b1;
                    oReq0_ready = ~grant_sel;
                    oReq1_ready = grant_sel;
                    oErr        = sel_oor;
                    if (!sel_oor) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pix_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            tx_q      <= '0;
            ty_q      <= '0;
            owner_q   <= 1'b0;
            row       <= '0;
            col       <= '0;
            tag_valid <= '0;
            tag_last  <= '0;
            tag_owner <= '0;
            tile_cnt  <= '0;
        end else begin
            if (grant && !sel_oor) begin
                tx_q    <= sel_tx;
                ty_q    <= sel_ty;
                owner_q <= grant_sel;
                row     <= '0;
                col     <= '0;
            end else if (rd_en) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            // Tags follow each read through the BRAM latency.
            tag_valid[0] <= rd_en;
            tag_last[0]  <= rd_en & issue_last;
            tag_owner[0] <= rd_en & owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end

            if (state == DRAIN && pix_last) begin
                tile_cnt <= tile_cnt + 11'd1;
            end
        end
    end

    assign oRd_en     = rd_en;
    assign oRd_addr   = rd_en ? addr_full[ADDR_W-1:0] : '0;
    assign oPix_valid = tag_valid[RD_LAT-1];
    assign oPix_last  = tag_last[RD_LAT-1];
    assign oPix_owner = tag_owner[RD_LAT-1];
    assign oPix_data  = oPix_valid ? iRd_data : 8'd0;
    assign oBusy      = (state != IDLE);
    assign oTile_cnt  = tile_cnt;
    assign dbg_state  = state;

endmodule

// File: tb/tb_tile_read_scheduler.sv
// Randomized scoreboard bench for tile_read_scheduler: a full-width instance plus an ADDR_W=8
// instance share one stimulus; expected reads and pixels come from a per-tile reference model.

module tb_tile_read_scheduler;

    localparam int IW = 32, IH = 16, TW = 16, TH = 16, RL = 2;
    localparam int TX_N = IW / TW, TY_N = IH / TH;

    logic        iClk, iRst;
    logic        iReq0_valid, iReq1_valid;
    logic [5:0]  iReq0_tx, iReq1_tx;
    logic [4:0]  iReq0_ty, iReq1_ty;
    logic [7:0]  iRd_data;

    logic        r0, r1, rd_en, pv, pl, po, err, busy;
    logic [18:0] rd_addr;
    logic [7:0]  pd;
    logic [10:0] tcnt;
    logic [1:0]  dbg;

    logic        r0_8, r1_8, rd_en8, pv8, pl8, po8, err8, busy8;
    logic [7:0]  rd_addr8;
    logic [7:0]  pd8;
    logic [10:0] tcnt8;
    logic [1:0]  dbg8;

    tile_read_scheduler #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TILE_WIDTH(TW), .TILE_HEIGHT(TH),
                          .ADDR_W(19), .RD_LAT(RL)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReq0_valid(iReq0_valid), .iReq0_tx(iReq0_tx), .iReq0_ty(iReq0_ty), .oReq0_ready(r0),
        .iReq1_valid(iReq1_valid), .iReq1_tx(iReq1_tx), .iReq1_ty(iReq1_ty), .oReq1_ready(r1),
        .oRd_en(rd_en), .oRd_addr(rd_addr), .iRd_data(iRd_data),
        .oPix_valid(pv), .oPix_data(pd), .oPix_last(pl), .oPix_owner(po),
        .oErr(err), .oBusy(busy), .oTile_cnt(tcnt), .dbg_state(dbg)
    );

    tile_read_scheduler #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TILE_WIDTH(TW), .TILE_HEIGHT(TH),
                          .ADDR_W(8), .RD_LAT(RL)) dut8 (
        .iClk(iClk), .iRst(iRst),
        .iReq0_valid(iReq0_valid), .iReq0_tx(iReq0_tx), .iReq0_ty(iReq0_ty), .oReq0_ready(r0_8),
        .iReq1_valid(iReq1_valid), .iReq1_tx(iReq1_tx), .iReq1_ty(iReq1_ty), .oReq1_ready(r1_8),
        .oRd_en(rd_en8), .oRd_addr(rd_addr8), .iRd_data(iRd_data),
        .oPix_valid(pv8), .oPix_data(pd8), .oPix_last(pl8), .oPix_owner(po8),
        .oErr(err8), .oBusy(busy8), .oTile_cnt(tcnt8), .dbg_state(dbg8)
    );

    // ---------------- clock ----------------
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0, n_pass = 0;
    logic [31:0] exp_addr_q[$];
    logic [9:0]  exp_pix_q[$];   // {owner, last, data}
    int          iss_q[$];
    int          rd_pops = 0;
    int          tiles_done = 0;
    logic [10:0] rq0[$], rq1[$]; // {tx, ty}
    logic        m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] mem_f(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd37 + 32'd11;
        return t[7:0];
    endfunction

    // ---------------- BRAM model: data appears RL cycles after the read ----------------
    logic [31:0] n0, n1;
    initial begin
        n0 = 0; n1 = 0; iRd_data = 8'd0;
        forever begin
            @(negedge iClk);
            n1 = n0;
            n0 = rd_en ? 32'(rd_addr) : 32'd0;
            @(posedge iClk);
            iRd_data = mem_f(n1);
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        logic [31:0] a;
        logic [9:0]  e;
        int          ic;
        @(negedge iClk);
        if (rd_en || rd_en8) begin
            if (exp_addr_q.size() == 0) begin
                check("rd_unexpected", 32'({rd_en, rd_en8}), 32'd0);
            end else begin
                a = exp_addr_q.pop_front();
                check("rd_en_both", 32'({rd_en, rd_en8}), 32'd3);
                check("rd_addr", 32'(rd_addr), 32'(a[18:0]));
                check("rd_addr8", 32'(rd_addr8), 32'(a[7:0]));
                iss_q.push_back(cyc);
                rd_pops++;
            end
        end
        if (pv || pv8) begin
            if (exp_pix_q.size() == 0) begin
                check("pix_unexpected", 32'({pv, pv8}), 32'd0);
            end else begin
                e = exp_pix_q.pop_front();
                check("pix_valid_both", 32'({pv, pv8}), 32'd3);
                check("pix_data", 32'({pd, pd8}), 32'({e[7:0], e[7:0]}));
                check("pix_last", 32'({pl, pl8}), 32'({e[8], e[8]}));
                check("pix_owner", 32'({po, po8}), 32'({e[9], e[9]}));
                if (iss_q.size() != 0) begin
                    ic = iss_q.pop_front();
                    check("pix_latency", 32'(cyc - ic), 32'(RL));
                end
                if (e[8]) begin
                    check("tile_cnt_at_last", 32'({tcnt, tcnt8}), 32'({tiles_done[10:0], tiles_done[10:0]}));
                    tiles_done++;
                end
            end
        end
        if (iRst) begin
            exp_addr_q.delete();
            exp_pix_q.delete();
            iss_q.delete();
            tiles_done = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive();
        iReq0_valid = (rq0.size() != 0);
        iReq1_valid = (rq1.size() != 0);
        {iReq0_tx, iReq0_ty} = (rq0.size() != 0) ? rq0[0] : 11'd0;
        {iReq1_tx, iReq1_ty} = (rq1.size() != 0) ? rq1[0] : 11'd0;
    endtask

    // Reference: a granted in-range tile produces TW*TH raster-order reads.
    task automatic push_tile(input logic [5:0] tx, input logic [4:0] ty, input logic owner);
        logic [31:0] a;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) begin
                a = 32'((int'(ty) * TH + r) * IW + int'(tx) * TW + c);
                exp_addr_q.push_back(a);
                exp_pix_q.push_back({owner, (r == TH - 1) && (c == TW - 1), mem_f(a)});
            end
        end
    endtask

    task automatic hs_step();
        logic        v0, v1, g, oor;
        logic [10:0] h;
        @(negedge iClk);
        v0 = iReq0_valid;
        v1 = iReq1_valid;
        if (r0 || r1 || r0_8 || r1_8) begin
            if (!(v0 || v1)) begin
                check("spurious_ready", 32'({r0, r1, r0_8, r1_8}), 32'd0);
            end else begin
`ifdef SCHED_STRICT_PRIO_EN
                g = !v0;
`else
                g = (v0 && v1) ? m_ptr : !v0;
`endif
                check("grant", 32'({r0, r1, r0_8, r1_8}), g ? 32'd5 : 32'd10);
                m_ptr = !g;
                h = g ? rq1.pop_front() : rq0.pop_front();
                oor = (int'(h[10:5]) >= TX_N) || (int'(h[4:0]) >= TY_N);
                check("err_at_grant", 32'({err, err8}), 32'({oor, oor}));
                check("busy_at_grant", 32'({busy, busy8}), 32'd0);
                if (!oor) push_tile(h[10:5], h[4:0], g);
            end
        end else if (err || err8) begin
            check("spurious_err", 32'({err, err8}), 32'd0);
        end
        tick();
        drive();
    endtask

    task automatic run_reqs();
        drive();
        for (int i = 0; i < 6000 && (rq0.size() != 0 || rq1.size() != 0); i++) hs_step();
        if (rq0.size() + rq1.size() != 0) begin
            check("grant_timeout", 32'(rq0.size() + rq1.size()), 32'd0);
            rq0.delete();
            rq1.delete();
            drive();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (exp_pix_q.size() != 0 || busy || busy8); i++) tick();
        check("idle_pending", 32'(exp_pix_q.size()), 32'd0);
        check("idle_busy", 32'({busy, busy8, dbg, dbg8}), 32'd0);
        check("idle_tile_cnt", 32'({tcnt, tcnt8}), 32'({tiles_done[10:0], tiles_done[10:0]}));
    endtask

    task automatic reset_dut();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        m_ptr = 1'b0;
        @(negedge iClk);
        check("rst_ctrl", 32'({rd_en, pv, pl, po, err, busy, r0, r1, dbg}), 32'd0);
        check("rst_ctrl8", 32'({rd_en8, pv8, pl8, po8, err8, busy8, r0_8, r1_8, dbg8}), 32'd0);
        check("rst_data", 32'({rd_addr, pd}), 32'd0);
        check("rst_data8", 32'({rd_addr8, pd8}), 32'd0);
        check("rst_tile_cnt", 32'({tcnt, tcnt8}), 32'd0);
        tick();
    endtask

    function automatic logic [10:0] rand_req();
        logic [5:0] tx;
        logic [4:0] ty;
        tx = 6'($urandom_range(0, 2));
        ty = ($urandom_range(0, 4) == 0) ? 5'd1 : 5'd0;
        return {tx, ty};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int base, n0r, n1r;
        iRst = 1'b1;
        rq0.delete();
        rq1.delete();
        drive();
        m_ptr = 1'b0;
        tick();
        tick();
        reset_dut();

        // single tile (1,0) from requester 0
        rq0.push_back({6'd1, 5'd0});
        run_reqs();
        wait_idle();

        // contention from reset: 0 first, then 1
        reset_dut();
        rq0.push_back({6'd0, 5'd0});
        rq1.push_back({6'd1, 5'd0});
        run_reqs();
        wait_idle();

        // fairness: both continuously valid for four tiles
        rq0.push_back({6'd0, 5'd0});
        rq0.push_back({6'd1, 5'd0});
        rq1.push_back({6'd1, 5'd0});
        rq1.push_back({6'd0, 5'd0});
        run_reqs();
        wait_idle();

        // out-of-range requests on each axis
        rq1.push_back({6'd2, 5'd0});
        run_reqs();
        wait_idle();
        rq0.push_back({6'd0, 5'd1});
        run_reqs();
        wait_idle();

        // reset around read 100, then a fresh tile must restart at row 0, col 0
        rq0.push_back({6'd1, 5'd0});
        drive();
        for (int i = 0; i < 50 && rq0.size() != 0; i++) hs_step();
        base = rd_pops;
        for (int i = 0; i < 400 && rd_pops < base + 100; i++) tick();
        reset_dut();
        repeat (4) tick();
        check("post_rst_quiet", 32'(exp_pix_q.size()), 32'd0);
        rq0.push_back({6'd1, 5'd0});
        run_reqs();
        wait_idle();

        // randomized mixes
        for (int k = 0; k < 5; k++) begin
            n0r = $urandom_range(0, 2);
            n1r = $urandom_range(1, 2);
            for (int j = 0; j < n0r; j++) rq0.push_back(rand_req());
            for (int j = 0; j < n1r; j++) rq1.push_back(rand_req());
            run_reqs();
            if ($urandom_range(0, 1) == 1) wait_idle();
            else repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

        check("queues_empty", 32'(exp_addr_q.size() + exp_pix_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/tile_read_scheduler.md
Name: tile_read_scheduler

Overview:
- Sequences the BRAM read port of the tile buffer. It arbitrates tile-fetch requests from two requesters and walks each granted tile in raster order inside the tile.
- Tracks BRAM read latency and emits a tagged pixel stream with a tile-last marker.
- Sits between the downstream tile consumers (requester 0/1) and the BRAM read port (enb/regceb/addrb side).

Parameters:
- IMG_WIDTH, 32, image width in pixels
- IMG_HEIGHT, 16, image height in pixels
- TILE_WIDTH, 16, tile width in pixels (power of 2)
- TILE_HEIGHT, 16, tile height in pixels (power of 2)
- ADDR_W, 19, BRAM address width
- RD_LAT, 2, BRAM read latency in cycles from oRd_en to valid iRd_data (output register enabled)

Ports:
- iClk  in  1  clock
- iRst  in  1  reset, synchronous, active-high
- iReq0_valid  in  1  requester 0 tile request
- iReq0_tx  in  6  requester 0 tile column index
- iReq0_ty  in  5  requester 0 tile row index
- oReq0_ready  out  1  one-cycle accept pulse for requester 0
- iReq1_valid, iReq1_tx, iReq1_ty, oReq1_ready  same as requester 0
- oRd_en  out  1  BRAM read enable (drives enb and regceb)
- oRd_addr  out  ADDR_W  BRAM read address
- iRd_data  in  8  BRAM read data
- oPix_valid  out  1  pixel valid
- oPix_data  out  8  pixel value
- oPix_last  out  1  last pixel of tile, coincident with oPix_valid
- oPix_owner  out  1  requester that owns the current pixel
- oErr  out  1  one-cycle pulse when an out-of-range request is dropped
- oBusy  out  1  high in any state other than IDLE
- oTile_cnt  out  11  count of completed tiles, wraps at 2047

Behaviour:
- Reset: when iRst=1 at a clock edge, all outputs go to 0, state goes to IDLE, the round-robin pointer goes to 0 (requester 0 favoured first), and all in-flight pipeline tags are cleared.
- Reset mid-tile aborts immediately. No pixel is emitted in the cycle after reset.
- States: IDLE, ISSUE, DRAIN.
- IDLE, no request valid: stay in IDLE.
- IDLE, one or both requests valid:
  - Grant per arbitration and pulse the granted oReqN_ready for 1 cycle.
  - Latch tx, ty and owner, clear row and column counters.
  - Go to ISSUE on the next cycle.
- Out-of-range request (tx >= IMG_WIDTH/TILE_WIDTH or ty >= IMG_HEIGHT/TILE_HEIGHT):
  - Still accepted (ready pulses) and oErr pulses in the same cycle.
  - No reads are issued, state stays IDLE, and the pointer still advances.
- Requesters hold valid and indices stable until ready. Dropping valid before ready is permitted; such a request is simply not granted.
- Arbitration (default): round-robin.
  - When both are valid, grant the requester the pointer favours; the pointer then favours the other.
  - When only one is valid, grant it and point at the other.
- ISSUE:
  - oRd_en=1 every cycle, one address per cycle.
  - oRd_addr = (ty*TILE_HEIGHT + row)*IMG_WIDTH + tx*TILE_WIDTH + col, computed at full precision and truncated to ADDR_W.
  - Column increments; at TILE_WIDTH-1 it wraps to 0 and row increments.
  - The last address (row=TILE_HEIGHT-1, col=TILE_WIDTH-1) is issued, then go to DRAIN.
  - Exactly TILE_WIDTH*TILE_HEIGHT reads per tile.
- Pipeline: a valid/last/owner tag shift register of depth RD_LAT.
  - oPix_valid, oPix_last and oPix_owner are high exactly RD_LAT cycles after the matching oRd_en.
  - oPix_data = iRd_data in the same cycle. Combinational pass-through is permitted.
- DRAIN:
  - oRd_en=0.
  - Wait until the tag pipeline is empty, i.e. the oPix_last cycle has occurred.
  - Increment oTile_cnt in the oPix_last cycle, then go to IDLE.
- Requests arriving during ISSUE or DRAIN are not granted until IDLE; ready stays 0 meanwhile.
- Throughput: back-to-back tiles have a 2-cycle bubble (DRAIN exit plus IDLE grant) after RD_LAT.
- No output backpressure: consumers sink one pixel per cycle.

Optional Feature:
- Macro: SCHED_STRICT_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins when both are valid, the round-robin pointer is removed, and requester 1 can starve.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single tile: req0 tx=1, ty=0 (32x16 image, 16x16 tiles) -> ready0 pulses once; 256 reads with addresses 16..31, 48..63, ..., 496..511; first oPix_valid exactly 2 cycles after first oRd_en; oPix_last on pixel 256 with owner=0; oTile_cnt=1.
- Contention: req0 (0,0) and req1 (1,0) valid in the same cycle from reset -> req0 granted first, req1 granted next IDLE; owners in order 0 then 1; oTile_cnt=2. With SCHED_STRICT_PRIO_EN and req0 re-asserted continuously -> req1 never granted.
- Fairness: both requesters continuously valid for 4 tiles, round-robin build -> grant order 0,1,0,1.
- Out-of-range: req1 tx=2, ty=0 -> ready1 and oErr pulse in the same cycle; no oRd_en; oTile_cnt unchanged; state IDLE.
- Reset mid-operation: iRst=1 for 1 cycle at read 100 of a tile -> next cycle all outputs 0 and oBusy=0; no stale oPix_valid afterwards; new request afterwards restarts at row 0, col 0.
- Address wrap: ADDR_W=8 with the 32x16 image and tile (1,0) -> oRd_addr truncated to 8 bits, so the last read is 0xFF.
